pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Parametrised stall/flush controller for the multistage pipeline.
//  - Merges N_STALL hazard-unit stall requests and N_FLUSH flush requests (skip/branch, exception cause).
//  - Unlike a plain OR merge, it stretches stalls to a requested length and holds a flush for FLUSH_CYC cycles.
//  - Drives PC/IF_ID hold, ID_EX bubble and IF flush, and counts stall cycles.
// PARAMETERS
//  N_STALL    2   number of stall request sources (HDU1, HDU2, ...)
//  N_FLUSH    2   number of flush request sources; index 0 = highest priority for flush_src
//  CNT_W      3   width of each per-source extra-stall length and of the hold counter
//  FLUSH_CYC  1   cycles if_flush stays asserted per accepted flush (1..2**CNT_W-1)
//  PERF_W     16  stall performance counter width
// PORTS
//  clk           in   1                clock, rising edge
//  rst           in   1                synchronous, active-high reset
//  stall_req     in   N_STALL          stall request, one bit per source
//  stall_len     in   N_STALL*CNT_W    extra hold cycles for source i, in bits [i*CNT_W +: CNT_W]
//  flush_req     in   N_FLUSH          flush request, one bit per source
//  pc_hold       out  1                PC must not update this cycle
//  if_id_hold    out  1                IF/ID register must not update this cycle
//  id_ex_bubble  out  1                insert bubble into ID/EX this cycle
//  if_flush      out  1                clear IF/ID this cycle
//  flush_src     out  N_FLUSH          one-hot source of the current flush; 0 when no flush
//  stall_cnt     out  PERF_W           saturating count of cycles with pc_hold=1
// BEHAVIOUR
//  - Reset: while rst=1, state=RUN, hold_cnt=0, flush_cnt=0 and stall_cnt=0.
//    Every output is forced to 0, regardless of the request inputs.
//  - States:
//    - RUN: no pending hold or flush.
//    - HOLD: hold_cnt>0.
//    - FLUSH: flush_cnt>0.
//  - Same-cycle response: a request affects the outputs combinationally in the cycle it is asserted (zero latency).
//  - any_stall = |stall_req; any_flush = |flush_req.
//  - Priority:
//    1. any_flush.
//    2. FLUSH state.
//    3. any_stall or HOLD.
//  - A new flush overrides stalls and clears hold_cnt.
//  - RUN/HOLD with any_flush:
//    - Outputs: if_flush=1, id_ex_bubble=1, pc_hold=0, if_id_hold=0.
//    - flush_src = lowest-index asserted bit of flush_req.
//    - Next cycle: hold_cnt=0.
//    - If FLUSH_CYC>1: flush_cnt=FLUSH_CYC-1 and go to FLUSH, remembering flush_src; otherwise go to RUN.
//  - FLUSH state:
//    - Outputs: if_flush=1, id_ex_bubble=1, pc_hold=0, if_id_hold=0, flush_src = the remembered source.
//    - Stall requests are ignored.
//    - flush_cnt decrements each cycle; go to RUN when it reaches 0.
//    - A new flush_req in FLUSH reloads flush_cnt=FLUSH_CYC-1 and updates flush_src to the new source.
//  - Stall (RUN/HOLD, no flush):
//    - If any_stall or hold_cnt>0: pc_hold=1, if_id_hold=1, id_ex_bubble=1.
//    - Next hold_cnt = max(hold_cnt-1 if hold_cnt>0 else 0, max over asserted i of stall_len[i]).
//    - Unsigned compare; no wrap: hold_cnt never underflows below 0.
//    - Go to HOLD if next hold_cnt>0, else RUN.
//    - stall_len of a deasserted source is ignored.
//  - stall_cnt increments each cycle pc_hold=1 and saturates at all-ones.
// STRUCTURE
//  - Shared pipeline package:
//    - state encoding localparams ST_RUN=2'd0, ST_HOLD=2'd1, ST_FLUSH=2'd2.
//    - CNT_W default and the stall/flush source index constants.
//  - Sub-module prio_onehot #(N): lowest-index-first one-hot select for flush_src.
//  - Otherwise a single module containing the FSM, hold/flush counters and the perf counter.
// TESTING (N_STALL=2, N_FLUSH=2, CNT_W=3, FLUSH_CYC=2)
//  1. Single-cycle stall:
//     - Stimulus: stall_req=01, stall_len[0]=0 for 1 cycle.
//     - Response: pc_hold=if_id_hold=id_ex_bubble=1 that cycle only; state stays RUN; stall_cnt=1.
//  2. Stretched stall:
//     - Stimulus: stall_req=10, stall_len[1]=3 for 1 cycle.
//     - Response: pc_hold=1 for 4 consecutive cycles, then 0; stall_cnt=4.
//  3. Max merge:
//     - Stimulus: stall_len[0]=2 at t0; then stall_req=10 with stall_len[1]=5 at t1.
//     - Response: hold_cnt=5 after t1; pc_hold high through t6.
//  4. Flush preempts stall:
//     - Stimulus: in HOLD with hold_cnt=3, flush_req=11.
//     - Response: same cycle if_flush=1, pc_hold=0, flush_src=01.
//     - Next cycle: FLUSH state, if_flush=1; then RUN with hold_cnt=0.
//  5. Flush reload:
//     - Stimulus: flush_req=10 in the FLUSH state.
//     - Response: flush_src=10; if_flush held 2 more cycles.
//  6. Reset mid-operation:
//     - Stimulus: rst=1 during HOLD with stall_req=11.
//     - Response: all outputs 0 that cycle; state RUN and stall_cnt=0 after the edge.
//  7. Perf counter saturation:
//     - Stimulus: pre-drive stall_cnt to 16'hFFFE, then 3 stall cycles.
//     - Response: stall_cnt reaches 16'hFFFF and stays there.

Source files
------------

// File: rtl/pipe_hazard_pkg.sv
// Shared pipeline-control package: FSM state encoding, default counter
// width and the symbolic indices of the stall/flush request sources.
package pipe_hazard_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HOLD  = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   localparam int CNT_W_DEF   = 3;

   localparam int STALL_HDU1  = 0;
   localparam int STALL_HDU2  = 1;

   // Lower index wins when several flush sources fire together.
   localparam int FLUSH_BRANCH = 0;
   localparam int FLUSH_EXCEPT = 1;

endpackage

// File: rtl/prio_onehot.sv
// Lowest-index-first one-hot select.
// Ports:
//   i_req     N-bit request vector
//   o_onehot  N-bit one-hot of the lowest set bit of i_req, 0 if none
module prio_onehot #(
   parameter int N = 2
) (
   input  logic [N-1:0] i_req,
   output logic [N-1:0] o_onehot
);

   // Two's-complement trick isolates the lowest set bit.
   assign o_onehot = i_req & (~i_req + N'(1));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the multistage pipeline. Merges hazard stall
// requests (stretched to a per-source length) and flush requests (held for
// FLUSH_CYC cycles), drives the pipeline hold/bubble/flush controls and
// counts stalled cycles.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_stall_req    one stall request bit per source
//   i_stall_len    extra hold cycles per source, CNT_W bits each
//   i_flush_req    one flush request bit per source (index 0 highest priority)
//   o_pc_hold, o_if_id_hold, o_id_ex_bubble, o_if_flush   pipeline controls
//   o_flush_src    one-hot source of the current flush, 0 when none
//   o_stall_cnt    saturating count of cycles with o_pc_hold=1
//
// state    | meaning
// ST_RUN   | nothing pending
// ST_HOLD  | hold counter non-zero, pipeline frozen
// ST_FLUSH | flush counter non-zero, IF still being flushed
module pipe_hazard_ctrl
   import pipe_hazard_pkg::*;
#(
   parameter int N_STALL   = 2,
   parameter int N_FLUSH   = 2,
   parameter int CNT_W     = CNT_W_DEF,
   parameter int FLUSH_CYC = 1,
   parameter int PERF_W    = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [N_STALL-1:0]       i_stall_req,
   input  logic [N_STALL*CNT_W-1:0] i_stall_len,
   input  logic [N_FLUSH-1:0]       i_flush_req,
   output logic                     o_pc_hold,
   output logic                     o_if_id_hold,
   output logic                     o_id_ex_bubble,
   output logic                     o_if_flush,
   output logic [N_FLUSH-1:0]       o_flush_src,
   output logic [PERF_W-1:0]        o_stall_cnt
);

   localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYC - 1);

   state_t             r_state,     w_state_n;
   logic [CNT_W-1:0]   r_hold_cnt,  w_hold_n;
   logic [CNT_W-1:0]   r_flush_cnt, w_flush_n;
   logic [N_FLUSH-1:0] r_flush_src, w_src_n;
   logic [PERF_W-1:0]  r_stall_cnt;

   logic               w_any_stall;
   logic               w_any_flush;
   logic [N_FLUSH-1:0] w_flush_sel;
   logic [CNT_W-1:0]   w_len_max;
   logic [CNT_W-1:0]   w_hold_dec;

   assign w_any_stall = |i_stall_req;
   assign w_any_flush = |i_flush_req;
   assign w_hold_dec  = (r_hold_cnt != '0) ? r_hold_cnt - CNT_W'(1) : '0;

   prio_onehot #(.N(N_FLUSH)) u_flush_prio (
      .i_req    (i_flush_req),
      .o_onehot (w_flush_sel)
   );

   // Longest requested stretch among asserted sources only.
   always_comb begin
      w_len_max = '0;
      for (int i = 0; i < N_STALL; i++) begin
         if (i_stall_req[i] && (i_stall_len[i*CNT_W +: CNT_W] > w_len_max))
            w_len_max = i_stall_len[i*CNT_W +: CNT_W];
      end
   end

   always_comb begin
      w_state_n      = r_state;
      w_hold_n       = r_hold_cnt;
      w_flush_n      = r_flush_cnt;
      w_src_n        = r_flush_src;
      o_pc_hold      = 1'b0;
      o_if_id_hold   = 1'b0;
      o_id_ex_bubble = 1'b0;
      o_if_flush     = 1'b0;
      o_flush_src    = '0;

      if (w_any_flush) begin
         // A new flush wins over everything, including a flush in progress.
         o_if_flush     = 1'b1;
         o_id_ex_bubble = 1'b1;
         o_flush_src    = w_flush_sel;
         w_hold_n       = '0;
         if (FLUSH_CYC > 1) begin
            w_flush_n = FLUSH_RELOAD;
            w_src_n   = w_flush_sel;
            w_state_n = ST_FLUSH;
         end else begin
            w_flush_n = '0;
            w_state_n = ST_RUN;
         end
      end else if (r_state == ST_FLUSH) begin
         o_if_flush     = 1'b1;
         o_id_ex_bubble = 1'b1;
         o_flush_src    = r_flush_src;
         w_hold_n       = '0;
         w_flush_n      = r_flush_cnt - CNT_W'(1);
         w_state_n      = (w_flush_n == '0) ? ST_RUN : ST_FLUSH;
      end else begin
         if (w_any_stall || (r_hold_cnt != '0)) begin
            o_pc_hold      = 1'b1;
            o_if_id_hold   = 1'b1;
            o_id_ex_bubble = 1'b1;
         end
         w_hold_n  = (w_len_max > w_hold_dec) ? w_len_max : w_hold_dec;
         w_state_n = (w_hold_n != '0) ? ST_HOLD : ST_RUN;
      end

      if (i_rst) begin
         o_pc_hold      = 1'b0;
         o_if_id_hold   = 1'b0;
         o_id_ex_bubble = 1'b0;
         o_if_flush     = 1'b0;
         o_flush_src    = '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_RUN;
         r_hold_cnt  <= '0;
         r_flush_cnt <= '0;
         r_flush_src <= '0;
         r_stall_cnt <= '0;
      end else begin
         r_state     <= w_state_n;
         r_hold_cnt  <= w_hold_n;
         r_flush_cnt <= w_flush_n;
         r_flush_src <= w_src_n;
         if (o_pc_hold && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + PERF_W'(1);
      end
   end

   assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (N_STALL=2, N_FLUSH=2, CNT_W=3,
// FLUSH_CYC=2). Inputs change 1 time unit after the rising edge, outputs
// are sampled 1 unit later, well clear of the next edge.
module tb_pipe_hazard_ctrl;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [1:0]  i_stall_req;
   logic [5:0]  i_stall_len;
   logic [1:0]  i_flush_req;
   logic        o_pc_hold;
   logic        o_if_id_hold;
   logic        o_id_ex_bubble;
   logic        o_if_flush;
   logic [1:0]  o_flush_src;
   logic [15:0] o_stall_cnt;

   int n_total = 0;
   int n_bad   = 0;

   pipe_hazard_ctrl #(
      .N_STALL(2), .N_FLUSH(2), .CNT_W(3), .FLUSH_CYC(2), .PERF_W(16)
   ) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_stall_req    (i_stall_req),
      .i_stall_len    (i_stall_len),
      .i_flush_req    (i_flush_req),
      .o_pc_hold      (o_pc_hold),
      .o_if_id_hold   (o_if_id_hold),
      .o_id_ex_bubble (o_id_ex_bubble),
      .o_if_flush     (o_if_flush),
      .o_flush_src    (o_flush_src),
      .o_stall_cnt    (o_stall_cnt)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      i_stall_req = 2'b00;
      i_stall_len = 6'd0;
      i_flush_req = 2'b00;
   endtask

   initial begin
      // reset with every request asserted
      i_rst = 1'b1; i_stall_req = 2'b11; i_stall_len = {3'd3, 3'd3}; i_flush_req = 2'b11;
      #2;
      chk("rst_pc_hold",  32'(o_pc_hold),      32'd0);
      chk("rst_if_id",    32'(o_if_id_hold),   32'd0);
      chk("rst_bubble",   32'(o_id_ex_bubble), 32'd0);
      chk("rst_if_flush", 32'(o_if_flush),     32'd0);
      chk("rst_src",      32'(o_flush_src),    32'd0);
      step();
      chk("rst_state",    32'(dut.r_state),    32'd0);
      chk("rst_cnt",      32'(o_stall_cnt),    32'd0);
      i_rst = 1'b0; idle_inputs();
      step();

      // 1: single-cycle stall
      i_stall_req = 2'b01; i_stall_len = 6'd0;
      settle();
      chk("t1_pc_hold", 32'(o_pc_hold),      32'd1);
      chk("t1_if_id",   32'(o_if_id_hold),   32'd1);
      chk("t1_bubble",  32'(o_id_ex_bubble), 32'd1);
      step(); idle_inputs(); settle();
      chk("t1_release", 32'(o_pc_hold),   32'd0);
      chk("t1_state",   32'(dut.r_state), 32'd0);
      chk("t1_cnt",     32'(o_stall_cnt), 32'd1);

      // 2: source 1 stretched by 3 -> 4 held cycles
      step();
      i_stall_req = 2'b10; i_stall_len = {3'd3, 3'd0};
      settle();
      chk("t2_hold0", 32'(o_pc_hold), 32'd1);
      step(); idle_inputs(); settle();
      chk("t2_state", 32'(dut.r_state), 32'd1);
      for (int k = 1; k < 4; k++) begin
         chk($sformatf("t2_hold%0d", k), 32'(o_pc_hold), 32'd1);
         step(); settle();
      end
      chk("t2_release", 32'(o_pc_hold),   32'd0);
      chk("t2_cnt",     32'(o_stall_cnt), 32'd5);

      // 3: max merge, 2 then 5 -> held t0..t6
      step();
      i_stall_req = 2'b01; i_stall_len = {3'd0, 3'd2};
      settle();
      chk("t3_t0", 32'(o_pc_hold), 32'd1);
      step();
      i_stall_req = 2'b10; i_stall_len = {3'd5, 3'd7};
      settle();
      chk("t3_t1", 32'(o_pc_hold), 32'd1);
      step(); idle_inputs(); settle();
      chk("t3_hold_cnt", 32'(dut.r_hold_cnt), 32'd5);
      for (int t = 2; t <= 6; t++) begin
         chk($sformatf("t3_t%0d", t), 32'(o_pc_hold), 32'd1);
         step(); settle();
      end
      chk("t3_t7", 32'(o_pc_hold),   32'd0);
      chk("t3_cnt", 32'(o_stall_cnt), 32'd12);

      // 4: flush preempts a hold of 3
      step();
      i_stall_req = 2'b01; i_stall_len = {3'd0, 3'd3};
      step(); idle_inputs(); settle();
      chk("t4_hold_cnt", 32'(dut.r_hold_cnt), 32'd3);
      i_flush_req = 2'b11;
      settle();
      chk("t4_if_flush", 32'(o_if_flush),     32'd1);
      chk("t4_pc_hold",  32'(o_pc_hold),      32'd0);
      chk("t4_bubble",   32'(o_id_ex_bubble), 32'd1);
      chk("t4_src",      32'(o_flush_src),    32'd1);
      step(); idle_inputs(); settle();
      chk("t4_state_fl", 32'(dut.r_state),  32'd2);
      chk("t4_if_flush2",32'(o_if_flush),   32'd1);
      chk("t4_src2",     32'(o_flush_src),  32'd1);
      chk("t4_pc_hold2", 32'(o_pc_hold),    32'd0);
      step(); settle();
      chk("t4_state_run",32'(dut.r_state),    32'd0);
      chk("t4_hold_zero",32'(dut.r_hold_cnt), 32'd0);
      chk("t4_no_flush", 32'(o_if_flush),     32'd0);
      chk("t4_src_zero", 32'(o_flush_src),    32'd0);
      chk("t4_cnt",      32'(o_stall_cnt),    32'd13);

      // 5: flush reload from FLUSH; stall ignored while flushing
      step();
      i_flush_req = 2'b01;
      step(); idle_inputs();
      i_flush_req = 2'b10;
      settle();
      chk("t5_src_new",  32'(o_flush_src), 32'd2);
      chk("t5_flush_a",  32'(o_if_flush),  32'd1);
      step(); idle_inputs();
      i_stall_req = 2'b01; i_stall_len = {3'd0, 3'd3};
      settle();
      chk("t5_flush_b",  32'(o_if_flush),  32'd1);
      chk("t5_src_kept", 32'(o_flush_src), 32'd2);
      chk("t5_stall_ign",32'(o_pc_hold),   32'd0);
      step(); idle_inputs(); settle();
      chk("t5_flush_end",32'(o_if_flush),     32'd0);
      chk("t5_hold_zero",32'(dut.r_hold_cnt), 32'd0);
      chk("t5_cnt",      32'(o_stall_cnt),    32'd13);

      // 6: reset in HOLD with both stall sources asserted
      i_stall_req = 2'b11; i_stall_len = {3'd4, 3'd2};
      step(); settle();
      chk("t6_state_hold", 32'(dut.r_state), 32'd1);
      i_rst = 1'b1;
      settle();
      chk("t6_pc_hold", 32'(o_pc_hold),      32'd0);
      chk("t6_bubble",  32'(o_id_ex_bubble), 32'd0);
      chk("t6_if_id",   32'(o_if_id_hold),   32'd0);
      step();
      chk("t6_state", 32'(dut.r_state),    32'd0);
      chk("t6_cnt",   32'(o_stall_cnt),    32'd0);
      chk("t6_hold",  32'(dut.r_hold_cnt), 32'd0);
      i_rst = 1'b0; idle_inputs();

      // 7: perf counter saturation after 65534 stalled cycles
      i_stall_req = 2'b01;
      repeat (65534) @(posedge i_clk);
      #1;
      chk("t7_pre", 32'(o_stall_cnt), 32'hFFFE);
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("t7_sat%0d", k), 32'(o_stall_cnt), 32'hFFFF);
      end
      idle_inputs();
      step();
      chk("t7_hold_off", 32'(o_pc_hold),   32'd0);
      chk("t7_stays",    32'(o_stall_cnt), 32'hFFFF);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
